bus_src_sel: RTL
================

// Module: bus_src_sel
//
// PURPOSE
//   Registered, parametrised N:1 source selector driving the CPU's shared datapath bus.
//   Decodes a 1-based source code (0 = idle), registers the chosen source onto bus_out
//   and flags bus_valid. Bad codes raise a sticky error.
//   Two modes:
//     - track: follows the selected source every cycle.
//     - snapshot: holds the value captured at selection.
//   Sits between the register file outputs and the ALU/memory bus inputs; the control
//   FSM drives sel/sel_valid.
//
// PARAMETERS
//   WIDTH    16                        data width of each source and of bus_out
//   NUM_SRC  16                        number of sources (>=1)
//   SEL_W    $clog2(NUM_SRC+1)         select code width (derived; do not override)
//
// PORTS
//   clk        in   1                clock, all state updates on rising edge
//   reset      in   1                asynchronous, active-high reset
//   src_bus    in   NUM_SRC*WIDTH    flattened sources; src k at [k*WIDTH +: WIDTH]
//   sel        in   SEL_W            source code: 0 = idle, k = src k-1, >NUM_SRC invalid
//   sel_valid  in   1                sel is sampled only when high
//   mode       in   1                0 = track, 1 = snapshot
//   err_clr    in   1                clears sel_err
//   bus_out    out  WIDTH            registered bus value
//   bus_valid  out  1                bus_out is driven by a selected source
//   cur_sel    out  SEL_W            currently latched code (0 when idle)
//   sel_err    out  1                sticky: invalid code seen
//
// BEHAVIOUR
//   - Reset (async, any time incl. mid-DRIVE):
//       bus_out=0, bus_valid=0, cur_sel=0, sel_err=0, state=IDLE.
//   - FSM states:
//       IDLE: bus_valid=0.
//       DRIVE: bus_valid=1.
//   - sel_valid & 1<=sel<=NUM_SRC, from either state:
//       next edge: cur_sel<=sel, bus_out<=src[sel-1], state<=DRIVE. Latency 1 cycle.
//   - sel_valid & sel==0:
//       next edge: state<=IDLE, cur_sel<=0, bus_out holds last value (never 0/X-forced).
//   - sel_valid & sel>NUM_SRC:
//       sel_err<=1; state, cur_sel and bus_out unchanged.
//   - No sel_valid, DRIVE, mode=0: bus_out<=src[cur_sel-1] every edge.
//   - No sel_valid, DRIVE, mode=1: bus_out holds.
//   - No sel_valid, IDLE: all hold.
//   - mode changes take effect at the next edge; no capture is triggered by a mode change alone.
//   - Reselecting the same code in snapshot mode re-captures the current source value.
//   - err_clr & new invalid code in the same cycle: set wins, sel_err=1.
//   - err_clr alone: sel_err<=0 next edge.
//   - All arithmetic is unsigned. Index = sel-1, computed in SEL_W bits only after the range check.
//   - NUM_SRC=1: SEL_W=1, code 1 is the only valid source, there are no invalid codes.
//
// STRUCTURE
//   - Shared package cpu_bus_pkg:
//       state enum {ST_IDLE, ST_DRIVE};
//       constant SEL_IDLE = 0;
//       function for the flattened-slice index.
//   - One sub-module: bus_src_decode.
//       Combinational: sel -> {is_idle, is_valid, idx}, parametrised on NUM_SRC.
//   - Top level holds the FSM, data register and error flag.
//
// TESTING  (WIDTH=16, NUM_SRC=16, src k = 16'h1000+k unless noted)
//   1. Assert reset mid-stream -> outputs 0/0/0/0 immediately (async); IDLE after release.
//   2. sel=3 valid, mode=0 -> next edge bus_out=16'h1002, bus_valid=1, cur_sel=3.
//      Then change src2 to 16'hBEEF -> bus_out=16'hBEEF one edge later.
//   3. mode=1, sel=5 captures 16'h1004. Change src4 to 16'h0000 -> bus_out stays 16'h1004.
//      Reselect 5 -> 16'h0000.
//   4. DRIVE on sel=16 (src15=16'h100F), then sel=0 valid -> bus_valid=0, cur_sel=0,
//      bus_out stays 16'h100F.
//   5. DRIVE on sel=2, then sel=17 or 31 -> sel_err=1, bus_out/cur_sel unchanged.
//      err_clr together with sel=20 -> sel_err stays 1. err_clr alone -> 0.
//   6. Back-to-back sel 1,2,3 on consecutive cycles, mode=0 -> bus_out
//      16'h1000,16'h1001,16'h1002 on successive edges, no gap in bus_valid.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU datapath bus source selector.
// Holds the FSM state encoding, the idle select code and the flattened-slice index helper.
package cpu_bus_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } bus_state_e;

  localparam int unsigned SEL_IDLE = 32'd0;

  // Low bit position of source idx inside the flattened source bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/bus_src_decode.sv
// Combinational select-code decoder: 1-based code -> idle flag, valid flag and 0-based index.
// The index is computed only after the range check, so out-of-range codes never produce a stray index.
module bus_src_decode
  import cpu_bus_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
  input  logic [SEL_W-1:0] sel,
  output logic             is_idle,
  output logic             is_valid,
  output logic [SEL_W-1:0] idx
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_SRC);

  // Classify the code and derive the source index.
  always_comb begin
    is_idle  = (sel == SEL_W'(SEL_IDLE));
    is_valid = !is_idle && (sel <= MAX_SEL);
    if (is_valid) begin
      idx = sel - SEL_W'(32'd1);
    end else begin
      idx = '0;
    end
  end

endmodule

// File: rtl/bus_src_sel.sv
// Registered N:1 source selector for the shared datapath bus, with track/snapshot modes
// and a sticky invalid-code flag.
module bus_src_sel
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 16,
  parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*WIDTH-1:0]   src_bus,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       sel_valid,
  input  logic                       mode,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       bus_valid,
  output logic [SEL_W-1:0]           cur_sel,
  output logic                       sel_err
);

  bus_state_e       state_q, state_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             err_q, err_d;

  logic             sel_is_idle, sel_is_valid;
  logic [SEL_W-1:0] sel_idx;
  logic             cur_is_idle, cur_is_valid;
  logic [SEL_W-1:0] cur_idx;
  logic [WIDTH-1:0] sel_data, cur_data;
  logic             take_new, go_idle, bad_code;

  bus_src_decode #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_dec_sel (
    .sel      (sel),
    .is_idle  (sel_is_idle),
    .is_valid (sel_is_valid),
    .idx      (sel_idx)
  );

  // Second decoder re-derives the index of the latched code for track mode.
  bus_src_decode #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_dec_cur (
    .sel      (cur_sel_q),
    .is_idle  (cur_is_idle),
    .is_valid (cur_is_valid),
    .idx      (cur_idx)
  );

  assign take_new = sel_valid && sel_is_valid;
  assign go_idle  = sel_valid && sel_is_idle;
  assign bad_code = sel_valid && !sel_is_idle && !sel_is_valid;

  // Source muxes for the incoming code and for the latched code.
  always_comb begin
    sel_data = '0;
    cur_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_idx == SEL_W'(k)) begin
        sel_data = src_bus[slice_lo(k, WIDTH) +: WIDTH];
      end else begin
        sel_data = sel_data;
      end
      if (cur_idx == SEL_W'(k)) begin
        cur_data = src_bus[slice_lo(k, WIDTH) +: WIDTH];
      end else begin
        cur_data = cur_data;
      end
    end
  end

  // State, data, select and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bus_q     <= '0;
      cur_sel_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_q     <= bus_d;
      cur_sel_q <= cur_sel_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (take_new) begin
      state_d = ST_DRIVE;
    end else if (go_idle) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and sticky error; an invalid code leaves bus, code and state untouched.
  always_comb begin
    bus_d     = bus_q;
    cur_sel_d = cur_sel_q;
    err_d     = err_q;
    if (take_new) begin
      bus_d     = sel_data;
      cur_sel_d = sel;
    end else if (go_idle) begin
      cur_sel_d = SEL_W'(SEL_IDLE);
    end else if (!sel_valid && (state_q == ST_DRIVE) && !mode && cur_is_valid) begin
      bus_d = cur_data;
    end else begin
      bus_d = bus_q;
    end
    if (bad_code) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus_valid = (state_q == ST_DRIVE);
    bus_out   = bus_q;
    cur_sel   = cur_sel_q;
    sel_err   = err_q;
  end

endmodule
